// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the memory controller slice.
//   ADDR_W_DEF  : default word-address width (512-word memory)
//   TIMEOUT_DEF : default number of REQ cycles tolerated without mem_ack
//   state_t     : memory-controller FSM state encoding
package cpu_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if -- request/acknowledge bus between the controller and memory.
//   mem_req   : request, held until ack or timeout (controller -> memory)
//   mem_we    : 1 = write, 0 = read, valid while mem_req
//   mem_addr  : word address
//   mem_wdata : write data
//   mem_ack   : completion (memory -> controller)
//   mem_rdata : read data, valid in the mem_ack cycle
// Modports: master = controller side, slave = memory side.
interface mem_ctrl_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl -- single-access memory controller between the CPU control unit
// and a request/ack word memory.
//   clk      : sole clock, rising edge
//   clr      : asynchronous active-low reset
//   Read     : start-read strobe (sampled in IDLE only)
//   Write    : start-write strobe (sampled in IDLE only)
//   addr     : word address from MAR
//   wdata    : write data from MDR
//   MdataIn  : read data to MDR; changes only on a successful read
//   done     : one-cycle completion pulse (success or error)
//   busy     : high whenever not IDLE
//   err      : one-cycle error pulse, coincident with done
//   mem      : memory bus (mem_ctrl_if.master)
// An access that addresses beyond the memory, or a Read+Write collision,
// goes straight to ERR without touching the memory bus.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] MdataIn,
  output logic        done,
  output logic        busy,
  output logic        err,
  mem_ctrl_if.master  mem
);

  // Last REQ cycle index (counter counts ack-less REQ cycles already spent).
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       op_we;
  logic [4:0] to_cnt;
  logic       start, collide, oor;

  assign start   = Read ^ Write;
  assign collide = Read & Write;
  assign oor     = |(addr >> ADDR_W);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    done        = 1'b0;
    err         = 1'b0;
    busy        = 1'b1;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (collide)    state_nx = S_ERR;
        else if (start) state_nx = oor ? S_ERR : S_REQ;
      end
      S_REQ: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = op_we;
        // ack in the final allowed cycle still wins over the timeout
        if (mem.mem_ack)            state_nx = S_DONE;
        else if (to_cnt == TO_LAST) state_nx = S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and read-data capture.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      MdataIn       <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      op_we         <= 1'b0;
      to_cnt        <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mem.mem_addr  <= addr[ADDR_W-1:0];
        mem.mem_wdata <= wdata;
        op_we         <= Write;
        to_cnt        <= '0;
      end
      if (state == S_REQ) begin
        if (mem.mem_ack) begin
          if (!op_we) MdataIn <= mem.mem_rdata;
        end else begin
          to_cnt <= to_cnt + 5'd1;
        end
      end
    end
  end

endmodule
